// File: rtl/rr_arb5_64bit.sv
// Round-robin arbiter for five burst producers sharing one 64-bit datapath.
// A grant is held for a whole burst (until a last beat or MAX_BURST accepted
// beats), the selected beat is registered into a single valid/ready output
// stage, and the pointer then advances past the released requester.
module rr_arb5_64bit #(
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        req_valid,
  input  logic [4:0]        req_last,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic [DATA_W-1:0] req_data3,
  input  logic [DATA_W-1:0] req_data4,
  output logic [4:0]        req_ready,
  output logic [2:0]        mux_sel,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [2:0]        m_src,
  input  logic              m_ready,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [2:0] SEL_NONE  = 3'b111;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  // Returns {found, index} of the first set bit scanning base, base+1, ... mod 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] valid,
                                         input logic [2:0] base);
    logic [3:0] sum;
    logic [2:0] cand;
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, base} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      cand = sum[2:0];
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic [2:0]          m_src_q, m_src_d;

  logic [3:0]          pick;
  logic                slot_free;
  logic                accept;
  logic [DATA_W-1:0]   mux_data;

  assign pick = rr_pick(req_valid, ptr_q);

  // 5:1 beat mux; an out-of-range select (nothing granted) yields zero.
  always_comb begin
    case (mux_sel)
      3'd0:    mux_data = req_data0;
      3'd1:    mux_data = req_data1;
      3'd2:    mux_data = req_data2;
      3'd3:    mux_data = req_data3;
      3'd4:    mux_data = req_data4;
      default: mux_data = '0;
    endcase
  end

  // Arbitration FSM, grant handshake and output-stage next state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_src_d    = m_src_q;
    req_ready  = '0;
    mux_sel    = SEL_NONE;
    busy       = 1'b0;
    accept     = 1'b0;
    slot_free  = !m_valid_q || m_ready;

    case (state_q)
      IDLE: begin
        if (pick[3]) begin
          gnt_d      = pick[2:0];
          beat_cnt_d = 8'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        mux_sel          = gnt_q;
        busy             = 1'b1;
        req_ready[gnt_q] = slot_free;
        accept           = req_valid[gnt_q] && slot_free;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Release on the requester's last beat or when the burst cap is hit.
          if (req_last[gnt_q] || (beat_cnt_d == BURST_MAX)) begin
            state_d = IDLE;
            ptr_d   = (gnt_q == 3'd4) ? 3'd0 : gnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A newly accepted beat overwrites the slot even if it drains this cycle.
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = mux_data;
      m_last_d  = req_last[gnt_q];
      m_src_d   = gnt_q;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a reset also drops a held beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      gnt_q      <= 3'd0;
      beat_cnt_q <= 8'd0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_src_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_src_q    <= m_src_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_src   = m_src_q;

endmodule

// File: tb/tb_rr_arb5_64bit.sv
// Directed bench for rr_arb5_64bit: single beat, pointer rotation, fairness,
// burst hold, forced release, backpressure and reset mid-burst.
module tb_rr_arb5_64bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid;
  logic [4:0]  req_last;
  logic [63:0] req_data0, req_data1, req_data2, req_data3, req_data4;
  logic [4:0]  req_ready;
  logic [2:0]  mux_sel;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic [2:0]  m_src;
  logic        m_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] F_BASE = 64'h0123_4567_89AB_CD00;
  localparam logic [63:0] B_BASE = 64'hB0B0_0000_0000_0000;
  localparam logic [63:0] C_BASE = 64'hC0C0_0000_0000_0000;
  localparam logic [63:0] D_BASE = 64'hD0D0_0000_0000_0000;
  localparam logic [63:0] E_BASE = 64'hE0E0_0000_0000_0000;

  rr_arb5_64bit #(.DATA_W(64), .MAX_BURST(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_data4 (req_data4),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_src     (m_src),
    .m_ready   (m_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] onehot;
    rst = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data0 = '0; req_data1 = '0; req_data2 = '0; req_data3 = '0; req_data4 = '0;
    m_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_m_valid",   64'(m_valid),   64'd0);
    chk("rst_mux_sel",   64'(mux_sel),   64'd7);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_m_data",    m_data,         64'd0);
    chk("rst_m_last",    64'(m_last),    64'd0);
    chk("rst_m_src",     64'(m_src),     64'd0);

    // Single beat from requester 2
    rst = 1'b0;
    req_valid = 5'b00100;
    req_last  = 5'b00100;
    req_data2 = 64'hDEAD_BEEF;
    settle();
    chk("idle_mux_sel",   64'(mux_sel),   64'd7);
    chk("idle_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("single_mux_sel",   64'(mux_sel),   64'd2);
    chk("single_req_ready", 64'(req_ready), 64'b00100);
    chk("single_busy",      64'(busy),      64'd1);
    tick();
    chk("single_m_valid", 64'(m_valid), 64'd1);
    chk("single_m_data",  m_data,       64'hDEAD_BEEF);
    chk("single_m_src",   64'(m_src),   64'd2);
    chk("single_m_last",  64'(m_last),  64'd1);
    chk("single_release", 64'(mux_sel), 64'd7);
    chk("single_busy_lo", 64'(busy),    64'd0);

    // ptr is now 3: with 0 and 3 pending, 3 must win
    req_valid = 5'b01001;
    req_last  = 5'b11111;
    tick();
    chk("ptr3_mux_sel", 64'(mux_sel), 64'd3);
    chk("ptr3_drained", 64'(m_valid), 64'd0);
    tick();
    chk("ptr3_m_src", 64'(m_src), 64'd3);
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Fairness: all five hold 1-beat bursts; order 0,1,2,3,4,0
    req_valid = 5'b11111;
    req_last  = 5'b11111;
    req_data0 = F_BASE + 64'd0;
    req_data1 = F_BASE + 64'd1;
    req_data2 = F_BASE + 64'd2;
    req_data3 = F_BASE + 64'd3;
    req_data4 = F_BASE + 64'd4;
    for (int k = 0; k < 6; k++) begin
      tick();
      onehot = 5'b00001 << (k % 5);
      chk("fair_mux_sel",   64'(mux_sel),   64'(k % 5));
      chk("fair_req_ready", 64'(req_ready), 64'(onehot));
      tick();
      chk("fair_m_src",  64'(m_src),   64'(k % 5));
      chk("fair_m_data", m_data,       F_BASE + 64'(k % 5));
      chk("fair_idle",   64'(mux_sel), 64'd7);
    end

    // Burst hold: requester 1 sends 4 beats while 0 and 3 wait (ptr=1)
    req_valid = 5'b01011;
    req_last  = 5'b01001;
    tick();
    chk("burst_grant1", 64'(mux_sel), 64'd1);
    for (int b = 1; b <= 4; b++) begin
      req_data1   = B_BASE + 64'(b);
      req_last[1] = (b == 4);
      req_last[0] = (b % 2 == 0);
      settle();
      chk("burst_req_ready", 64'(req_ready), 64'b00010);
      tick();
      chk("burst_m_valid", 64'(m_valid), 64'd1);
      chk("burst_m_src",   64'(m_src),   64'd1);
      chk("burst_m_data",  m_data,       B_BASE + 64'(b));
      chk("burst_m_last",  64'(m_last),  64'(b == 4));
    end
    chk("burst_idle", 64'(mux_sel), 64'd7);
    req_valid = 5'b01001;
    req_last  = 5'b01001;
    tick();
    chk("burst_next3", 64'(mux_sel), 64'd3);
    tick();
    chk("burst_src3", 64'(m_src), 64'd3);
    req_valid = 5'b00001;
    tick();
    chk("burst_next0", 64'(mux_sel), 64'd0);
    tick();
    chk("burst_src0", 64'(m_src), 64'd0);
    req_valid = '0;

    // Forced release: requester 4 streams without last, 0 pending (ptr=1)
    req_valid = 5'b10001;
    req_last  = 5'b00001;
    tick();
    chk("force_grant4", 64'(mux_sel), 64'd4);
    for (int b = 1; b <= 16; b++) begin
      req_data4 = C_BASE + 64'(b);
      settle();
      chk("force_req_ready", 64'(req_ready), 64'b10000);
      tick();
      chk("force_m_data", m_data,      C_BASE + 64'(b));
      chk("force_m_last", 64'(m_last), 64'd0);
      chk("force_m_src",  64'(m_src),  64'd4);
    end
    chk("force_released", 64'(mux_sel), 64'd7);
    chk("force_busy_lo",  64'(busy),    64'd0);
    tick();
    chk("force_ptr0", 64'(mux_sel), 64'd0);
    tick();
    chk("force_src0", 64'(m_src), 64'd0);
    req_valid = 5'b10000;
    tick();
    chk("force_regrant4", 64'(mux_sel), 64'd4);
    for (int b = 17; b <= 20; b++) begin
      req_data4   = C_BASE + 64'(b);
      req_last[4] = (b == 20);
      settle();
      tick();
      chk("force_tail_data", m_data,      C_BASE + 64'(b));
      chk("force_tail_last", 64'(m_last), 64'(b == 20));
    end
    req_valid = '0;
    req_last  = '0;

    // Backpressure: m_ready low for 3 cycles mid-burst (ptr=0, only 2 pending)
    req_valid = 5'b00100;
    req_data2 = D_BASE + 64'd1;
    tick();
    chk("bp_grant2", 64'(mux_sel), 64'd2);
    tick();
    chk("bp_beat1", m_data, D_BASE + 64'd1);
    m_ready   = 1'b0;
    req_data2 = D_BASE + 64'd2;
    settle();
    for (int h = 0; h < 3; h++) begin
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_m_data",    m_data,         D_BASE + 64'd1);
      chk("bp_m_valid",   64'(m_valid),   64'd1);
      tick();
    end
    m_ready = 1'b1;
    settle();
    chk("bp_resume_ready", 64'(req_ready), 64'b00100);
    tick();
    chk("bp_beat2",       m_data,       D_BASE + 64'd2);
    chk("bp_drain_valid", 64'(m_valid), 64'd1);
    req_data2 = D_BASE + 64'd3;
    req_last  = 5'b00100;
    tick();
    chk("bp_beat3", m_data,      D_BASE + 64'd3);
    chk("bp_last",  64'(m_last), 64'd1);
    req_valid = '0;
    req_last  = '0;
    tick();
    chk("bp_empty", 64'(m_valid), 64'd0);

    // Reset mid-burst (ptr=3): requester 4 bursts, rst during beat 2
    req_valid = 5'b10000;
    req_data4 = E_BASE + 64'd1;
    tick();
    chk("rstm_grant4", 64'(mux_sel), 64'd4);
    tick();
    chk("rstm_beat1", m_data, E_BASE + 64'd1);
    req_data4 = E_BASE + 64'd2;
    rst = 1'b1;
    tick();
    chk("rstm_m_valid",   64'(m_valid),   64'd0);
    chk("rstm_mux_sel",   64'(mux_sel),   64'd7);
    chk("rstm_req_ready", 64'(req_ready), 64'd0);
    chk("rstm_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    req_valid = 5'b01010;
    tick();
    chk("rstm_ptr0", 64'(mux_sel), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
